pipe_stage_reg: RTL and testbench

//  Generic parametrised pipeline stage register for the 16-bit RISC core; replaces hand-built per-stage dff arrays.

---
 rtl/pipe_stage_reg_pkg.sv | 36 +++
 rtl/pipe_stage_reg_slot.sv | 35 +++
 rtl/pipe_stage_reg.sv | 157 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register: occupancy encodings,
// the bubble control value and the occupancy transition helper.
package pipe_stage_reg_pkg;

  // Number of entries held by the stage (main slot plus optional skid slot)
  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_TWO   = 2'd2
  } occ_t;

  // Every control bit of a bubble takes this value, so downstream enables stay off
  localparam logic BUBBLE_CTRL_BIT = 1'b0;

  // Occupancy after one clock, given this cycle's transfers; flush always empties
  function automatic occ_t next_occ(input occ_t cur, input logic accept,
                                    input logic emit, input logic flush);
    occ_t nxt;
    nxt = cur;
    if (flush) begin
      nxt = PIPE_EMPTY;
    end else begin
      case (cur)
        PIPE_EMPTY: if (accept) nxt = PIPE_ONE;
        PIPE_ONE: begin
          if (accept && !emit)      nxt = PIPE_TWO;
          else if (!accept && emit) nxt = PIPE_EMPTY;
        end
        PIPE_TWO:   if (emit) nxt = PIPE_ONE;
        default:    nxt = PIPE_EMPTY;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One (valid, ctrl, data) register of a pipeline stage. Clear squashes the
// entry and zeroes its control bits but leaves the payload untouched.
module pipe_stage_reg_slot #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);
  import pipe_stage_reg_pkg::*;

  // Clear wins over load so a squash can never be undone by a same-cycle write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= {CTRL_W{BUBBLE_CTRL_BIT}};
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= in_ctrl;
      data  <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush,
// bubble insertion, optional 2-entry skid buffer and a stall cycle counter.
module pipe_stage_reg #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 12,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);
  import pipe_stage_reg_pkg::*;

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;

  generate
    if (SKID) begin : g_skid
      occ_t              occ;
      occ_t              occ_nxt;
      logic              ready_q;
      logic              accept;
      logic              emit;
      logic              main_load;
      logic              main_clear;
      logic              skid_load;
      logic              skid_clear;
      logic [CTRL_W-1:0] main_in_ctrl;
      logic [DATA_W-1:0] main_in_data;
      logic              skid_valid;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [DATA_W-1:0] skid_data;

      assign accept  = in_valid & ready_q;
      assign emit    = main_valid & out_ready;
      assign occ_nxt = next_occ(occ, accept, emit, flush);

      // Steer loads/clears of the two slots from occupancy and this cycle's transfers
      always_comb begin
        main_load    = 1'b0;
        main_clear   = 1'b0;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        main_in_ctrl = in_ctrl;
        main_in_data = in_data;
        if (flush) begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end else begin
          case (occ)
            PIPE_EMPTY: main_load = accept;
            PIPE_ONE: begin
              if (accept && emit) main_load  = 1'b1;
              else if (accept)    skid_load  = 1'b1;
              else if (emit)      main_clear = 1'b1;
            end
            PIPE_TWO: begin
              if (emit && skid_valid) begin
                main_load    = 1'b1;
                main_in_ctrl = skid_ctrl;
                main_in_data = skid_data;
                skid_clear   = 1'b1;
              end
            end
            default: begin
              main_clear = 1'b1;
              skid_clear = 1'b1;
            end
          endcase
        end
      end

      // Occupancy and the registered in_ready; ready drops only when both slots fill
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          occ     <= PIPE_EMPTY;
          ready_q <= 1'b1;
        end else begin
          occ     <= occ_nxt;
          ready_q <= (occ_nxt != PIPE_TWO);
        end
      end

      assign in_ready = ready_q;

      pipe_stage_reg_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (main_load),
        .clear   (main_clear),
        .in_ctrl (main_in_ctrl),
        .in_data (main_in_data),
        .valid   (main_valid),
        .ctrl    (main_ctrl),
        .data    (main_data)
      );

      pipe_stage_reg_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clear   (skid_clear),
        .in_ctrl (in_ctrl),
        .in_data (in_data),
        .valid   (skid_valid),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
      );
    end else begin : g_single
      logic accept;
      logic emit;
      logic main_clear;

      assign in_ready   = out_ready | ~main_valid;
      assign accept     = in_valid & in_ready;
      assign emit       = main_valid & out_ready;
      assign main_clear = flush | (emit & ~accept);

      pipe_stage_reg_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .clear   (main_clear),
        .in_ctrl (in_ctrl),
        .in_data (in_data),
        .valid   (main_valid),
        .ctrl    (main_ctrl),
        .data    (main_data)
      );
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : {CTRL_W{BUBBLE_CTRL_BIT}};

  // Saturating count of stalled cycles; only reset clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: one skid-buffered stage (a_*) and one single-slot stage
// with a 4-bit stall counter (b_*), each checked against a queue model.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        check_en;

  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [15:0] a_in_data, a_out_data, a_stall_cnt;
  logic [11:0] a_in_ctrl, a_out_ctrl;

  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [15:0] b_in_data, b_out_data;
  logic [11:0] b_in_ctrl, b_out_ctrl;
  logic [3:0]  b_stall_cnt;

  int vectors;
  int miscompares;

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(12), .SKID(1'b1), .CNT_W(16)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .in_ctrl   (a_in_ctrl),
    .flush     (a_flush),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_ctrl  (a_out_ctrl),
    .stall_cnt (a_stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(12), .SKID(1'b0), .CNT_W(4)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_ctrl   (b_in_ctrl),
    .flush     (b_flush),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_ctrl  (b_out_ctrl),
    .stall_cnt (b_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each stage is a FIFO of {ctrl,data} with capacity 2 (a) or 1 (b)
  logic [27:0] qa[$];
  logic [27:0] qb[$];
  logic [15:0] a_last, b_last, a_cnt;
  logic [3:0]  b_cnt;
  logic        a_rdy;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      qa.delete();
      a_last = 16'h0;
      a_cnt  = 16'h0;
      a_rdy  = 1'b1;
    end else begin
      logic acc, emit;
      acc  = a_in_valid & a_rdy;
      emit = (qa.size() > 0) & a_out_ready;
      if ((qa.size() > 0) && !a_out_ready && (a_cnt != 16'hFFFF)) a_cnt = a_cnt + 16'd1;
      if (a_flush) qa.delete();
      else begin
        if (emit) void'(qa.pop_front());
        if (acc) qa.push_back({a_in_ctrl, a_in_data});
      end
      if (qa.size() > 0) a_last = qa[0][15:0];
      a_rdy = (qa.size() < 2);
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      qb.delete();
      b_last = 16'h0;
      b_cnt  = 4'h0;
    end else begin
      logic acc, emit;
      acc  = b_in_valid & (b_out_ready | (qb.size() == 0));
      emit = (qb.size() > 0) & b_out_ready;
      if ((qb.size() > 0) && !b_out_ready && (b_cnt != 4'hF)) b_cnt = b_cnt + 4'd1;
      if (b_flush) qb.delete();
      else begin
        if (emit) void'(qb.pop_front());
        if (acc) qb.push_back({b_in_ctrl, b_in_data});
      end
      if (qb.size() > 0) b_last = qb[0][15:0];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both stages against the model, away from the clock edge
  always @(negedge clk) begin
    if (rst && check_en) begin
      logic        va, vb;
      logic [11:0] ca, cb;
      va = (qa.size() > 0);
      vb = (qb.size() > 0);
      ca = va ? qa[0][27:16] : 12'h0;
      cb = vb ? qb[0][27:16] : 12'h0;
      checkOutput("a_out_valid", {31'b0, a_out_valid}, {31'b0, va});
      checkOutput("a_out_ctrl",  {20'b0, a_out_ctrl},  {20'b0, ca});
      checkOutput("a_out_data",  {16'b0, a_out_data},  {16'b0, a_last});
      checkOutput("a_in_ready",  {31'b0, a_in_ready},  {31'b0, a_rdy});
      checkOutput("a_stall_cnt", {16'b0, a_stall_cnt}, {16'b0, a_cnt});
      checkOutput("b_out_valid", {31'b0, b_out_valid}, {31'b0, vb});
      checkOutput("b_out_ctrl",  {20'b0, b_out_ctrl},  {20'b0, cb});
      checkOutput("b_out_data",  {16'b0, b_out_data},  {16'b0, b_last});
      checkOutput("b_in_ready",  {31'b0, b_in_ready},  {31'b0, (b_out_ready | ~vb)});
      checkOutput("b_stall_cnt", {28'b0, b_stall_cnt}, {28'b0, b_cnt});
    end
  end

  task automatic applyStimulus(input bit sel_b, input logic v, input logic [15:0] d,
                               input logic f, input logic r);
    if (!sel_b) begin
      a_in_valid = v; a_in_data = d; a_in_ctrl = 12'h800 | d[11:0];
      a_flush = f; a_out_ready = r;
    end else begin
      b_in_valid = v; b_in_data = d; b_in_ctrl = 12'h400 | d[11:0];
      b_flush = f; b_out_ready = r;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; check_en = 1'b0;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    repeat (2) tick();
    rst = 1'b1;
    check_en = 1'b1;
    checkOutput("reset a_in_ready", {31'b0, a_in_ready}, 32'd1);
    checkOutput("reset a_out_valid", {31'b0, a_out_valid}, 32'd0);

    // Streaming through the skid stage
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 1'b1, 16'(i), 1'b0, 1'b1);
      tick();
      checkOutput("stream data", {16'b0, a_out_data}, 32'(i));
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    checkOutput("bubble ctrl", {20'b0, a_out_ctrl}, 32'h0);
    checkOutput("bubble data hold", {16'b0, a_out_data}, 32'h10);

    // Stall with skid: A then B, then idle under back-pressure
    applyStimulus(1'b0, 1'b1, 16'h00A0, 1'b0, 1'b0); tick();
    applyStimulus(1'b0, 1'b1, 16'h00B0, 1'b0, 1'b0); tick();
    checkOutput("skid in_ready low", {31'b0, a_in_ready}, 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("stall count", {16'b0, a_stall_cnt}, 32'd4);
    checkOutput("stall head", {16'b0, a_out_data}, 32'h00A0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1); tick();
    checkOutput("release B next", {16'b0, a_out_data}, 32'h00B0);
    checkOutput("release ready", {31'b0, a_in_ready}, 32'd1);
    tick();
    checkOutput("drained", {31'b0, a_out_valid}, 32'd0);

    // Flush while two entries are held and a new one is offered
    applyStimulus(1'b0, 1'b1, 16'h00D0, 1'b0, 1'b0); tick();
    applyStimulus(1'b0, 1'b1, 16'h00E0, 1'b0, 1'b0); tick();
    applyStimulus(1'b0, 1'b1, 16'h00F0, 1'b1, 1'b0); tick();
    checkOutput("flush valid", {31'b0, a_out_valid}, 32'd0);
    checkOutput("flush ctrl", {20'b0, a_out_ctrl}, 32'h0);
    checkOutput("flush ready", {31'b0, a_in_ready}, 32'd1);
    applyStimulus(1'b0, 1'b1, 16'h0123, 1'b0, 1'b1); tick();
    checkOutput("after flush data", {16'b0, a_out_data}, 32'h0123);
    checkOutput("after flush ctrl", {20'b0, a_out_ctrl}, 32'h923);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1); tick();

    // Single-slot stage: combinational ready under stall
    applyStimulus(1'b1, 1'b1, 16'h0011, 1'b0, 1'b1); tick();
    applyStimulus(1'b1, 1'b1, 16'h0022, 1'b0, 1'b0); #1;
    checkOutput("b ready same cycle", {31'b0, b_in_ready}, 32'd0);
    tick(); tick();
    checkOutput("b held", {16'b0, b_out_data}, 32'h0011);
    applyStimulus(1'b1, 1'b1, 16'h0022, 1'b0, 1'b1); #1;
    checkOutput("b ready on release", {31'b0, b_in_ready}, 32'd1);
    tick();
    checkOutput("b pass-through", {16'b0, b_out_data}, 32'h0022);

    // Saturation of the 4-bit counter
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    repeat (20) tick();
    checkOutput("b saturate", {28'b0, b_stall_cnt}, 32'hF);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1); tick();

    // Reset mid-stream, checked before any clock edge
    applyStimulus(1'b0, 1'b1, 16'h0055, 1'b0, 1'b0); tick();
    applyStimulus(1'b0, 1'b1, 16'h0066, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h0077, 1'b0, 1'b0); tick();
    #2 rst = 1'b0;
    #1;
    checkOutput("rst a_out_valid", {31'b0, a_out_valid}, 32'd0);
    checkOutput("rst a_out_ctrl", {20'b0, a_out_ctrl}, 32'h0);
    checkOutput("rst a_out_data", {16'b0, a_out_data}, 32'h0);
    checkOutput("rst a_stall_cnt", {16'b0, a_stall_cnt}, 32'h0);
    checkOutput("rst a_in_ready", {31'b0, a_in_ready}, 32'd1);
    checkOutput("rst b_out_valid", {31'b0, b_out_valid}, 32'd0);
    checkOutput("rst b_stall_cnt", {28'b0, b_stall_cnt}, 32'h0);
    applyStimulus(1'b0, 1'b1, 16'h0099, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("post-reset entry", {16'b0, a_out_data}, 32'h0099);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
